// File: rtl/perceptron_seq_if.sv
// Host-side bundle for perceptron_seq: evaluation request, weight writes and result.
// The label signal exists only when PERCEPTRON_TRAIN_EN is defined.
interface perceptron_seq_if #(
   parameter int N     = 4,
   parameter int ACC_W = 10
);
   localparam int AW = $clog2(N);

   logic             start;
   logic [N*6-1:0]   x_in;
   logic [ACC_W-1:0] threshold;
   logic             w_we;
   logic [AW-1:0]    w_addr;
   logic [5:0]       w_data;
`ifdef PERCEPTRON_TRAIN_EN
   logic             label;
`endif
   logic             busy;
   logic             done;
   logic             y;
   logic [ACC_W-1:0] acc;

   modport master (
`ifdef PERCEPTRON_TRAIN_EN
      output label,
`endif
      output start, x_in, threshold, w_we, w_addr, w_data,
      input  busy, done, y, acc
   );

   modport slave (
`ifdef PERCEPTRON_TRAIN_EN
      input  label,
`endif
      input  start, x_in, threshold, w_we, w_addr, w_data,
      output busy, done, y, acc
   );
endinterface

// File: rtl/perceptron_seq.sv
// Single-neuron perceptron sequencer: one 6x6 MAC per cycle over N Q3.3 inputs, step activation.
// Optional online weight update compiled in with PERCEPTRON_TRAIN_EN.
module perceptron_seq #(
   parameter int N     = 4,
   parameter int ACC_W = 10
) (
   input  logic           clk,
   input  logic           reset_l,
   perceptron_seq_if.slave bus
);
   localparam int AW = $clog2(N);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_MAC  = 3'd1,
      S_ACT  = 3'd2,
`ifdef PERCEPTRON_TRAIN_EN
      S_UPD  = 3'd3,
`endif
      S_DONE = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [AW-1:0]    idx_q, idx_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [ACC_W-1:0] acc_out_q, acc_out_d;
   logic [ACC_W-1:0] thr_q, thr_d;
   logic             y_q, y_d;
   logic [N*6-1:0]   x_q, x_d;
   logic [5:0]       w_q [N];
   logic [5:0]       w_d [N];
`ifdef PERCEPTRON_TRAIN_EN
   logic             label_q, label_d;
   logic [6:0]       w_inc;
   logic [5:0]       w_upd;
`endif

   logic [5:0]       x_sel, w_sel;
   logic [5:0]       prod;
   logic [ACC_W:0]   acc_sum;
   logic [ACC_W-1:0] acc_mac;
   logic             y_act;

   // Shared datapath operands are steered by idx for both MAC and UPD.
   always_comb begin
      x_sel = '0;
      w_sel = '0;
      for (int i = 0; i < N; i++) begin
         if (idx_q == AW'(i)) begin
            x_sel = x_q[6*i +: 6];
            w_sel = w_q[i];
         end
      end
   end

   assign prod    = 6'((9'(x_sel) * 9'(w_sel)) >> 3);
   assign acc_sum = {1'b0, acc_q} + (ACC_W+1)'(prod);
   assign acc_mac = acc_sum[ACC_W] ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
   assign y_act   = (acc_q >= thr_q);

`ifdef PERCEPTRON_TRAIN_EN
   // An update only happens on error, so y_q=0 implies label=1 (increase).
   always_comb begin
      w_inc = {1'b0, w_sel} + {1'b0, x_sel};
      if (!y_q) begin
         w_upd = w_inc[6] ? 6'h3f : w_inc[5:0];
      end else begin
         w_upd = (w_sel > x_sel) ? (w_sel - x_sel) : 6'd0;
      end
   end
`endif

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      acc_d     = acc_q;
      acc_out_d = acc_out_q;
      thr_d     = thr_q;
      y_d       = y_q;
      x_d       = x_q;
      w_d       = w_q;
`ifdef PERCEPTRON_TRAIN_EN
      label_d   = label_q;
`endif
      case (state_q)
         S_IDLE: begin
            // The write lands before MAC reads any weight, so a same-cycle start sees it.
            if (bus.w_we) begin
               for (int i = 0; i < N; i++) begin
                  if (bus.w_addr == AW'(i)) w_d[i] = bus.w_data;
               end
            end
            if (bus.start) begin
               x_d     = bus.x_in;
               thr_d   = bus.threshold;
`ifdef PERCEPTRON_TRAIN_EN
               label_d = bus.label;
`endif
               acc_d   = '0;
               idx_d   = '0;
               state_d = S_MAC;
            end
         end
         S_MAC: begin
            acc_d = acc_mac;
            if (idx_q == AW'(N-1)) begin
               idx_d   = '0;
               state_d = S_ACT;
            end else begin
               idx_d = idx_q + AW'(1);
            end
         end
         S_ACT: begin
            y_d       = y_act;
            acc_out_d = acc_q;
            idx_d     = '0;
            state_d   = S_DONE;
`ifdef PERCEPTRON_TRAIN_EN
            if (label_q != y_act) state_d = S_UPD;
`endif
         end
`ifdef PERCEPTRON_TRAIN_EN
         S_UPD: begin
            for (int i = 0; i < N; i++) begin
               if (idx_q == AW'(i)) w_d[i] = w_upd;
            end
            if (idx_q == AW'(N-1)) begin
               idx_d   = '0;
               state_d = S_DONE;
            end else begin
               idx_d = idx_q + AW'(1);
            end
         end
`endif
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         acc_q     <= '0;
         acc_out_q <= '0;
         thr_q     <= '0;
         y_q       <= 1'b0;
         x_q       <= '0;
         for (int i = 0; i < N; i++) w_q[i] <= '0;
`ifdef PERCEPTRON_TRAIN_EN
         label_q   <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         acc_q     <= acc_d;
         acc_out_q <= acc_out_d;
         thr_q     <= thr_d;
         y_q       <= y_d;
         x_q       <= x_d;
         for (int i = 0; i < N; i++) w_q[i] <= w_d[i];
`ifdef PERCEPTRON_TRAIN_EN
         label_q   <= label_d;
`endif
      end
   end

   assign bus.busy = (state_q != S_IDLE);
   assign bus.done = (state_q == S_DONE);
   assign bus.y    = y_q;
   assign bus.acc  = acc_out_q;
endmodule
